nios2_freertos_tick_master: RTL and testbench

NIOS2_FREERTOS_TICK_MASTER -- requirements
Module: nios2_freertos_tick_master

---
 rtl/nios2_freertos_tick_master_if.sv | 26 ++
 rtl/nios2_freertos_tick_master.sv | 162 ++++++++++++++++
 tb/tb_nios2_freertos_tick_master.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_freertos_tick_master_if.sv
// Avalon-MM bus between the tick master and an interval-timer slave.
// Handshake: no waitrequest; a write completes in the single cycle chipselect=1/write_n=0, a read holds
// chipselect=1/write_n=1/address for two cycles and readdata (registered by the slave) is valid in the second.
interface nios2_freertos_tick_master_if;
   logic [2:0]  av_address;
   logic        av_chipselect;
   logic        av_write_n;
   logic [15:0] av_writedata;
   logic [15:0] av_readdata;

   modport master (
      output av_address,
      output av_chipselect,
      output av_write_n,
      output av_writedata,
      input  av_readdata
   );

   modport slave (
      input  av_address,
      input  av_chipselect,
      input  av_write_n,
      input  av_writedata,
      output av_readdata
   );
endinterface

// File: rtl/nios2_freertos_tick_master.sv
// Programs an interval timer over Avalon-MM, then services each timer interrupt:
// clears TO, snapshots the counter, reads it back and counts the tick.
module nios2_freertos_tick_master #(
   parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
   parameter bit          CONTINUOUS     = 1'b1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic [31:0]                         period,
   input  logic                                timer_irq,
   nios2_freertos_tick_master_if.master        av,
   output logic [31:0]                         tick_count,
   output logic                                tick_pulse,
   output logic [31:0]                         snap_value,
   output logic                                busy,
   output logic [3:0]                          state_dbg
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_PERL  = 4'd1,
      WR_PERH  = 4'd2,
      WR_CTRL  = 4'd3,
      WAIT_IRQ = 4'd4,
      CLR      = 4'd5,
      SNAP     = 4'd6,
      RD_L     = 4'd7,
      RD_H     = 4'd8,
      STOP     = 4'd9
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] period_q, period_d;
   logic        rd_phase_q, rd_phase_d;
   logic [15:0] snap_lo_q, snap_lo_d;
   logic [31:0] snap_q, snap_d;
   logic [31:0] tick_count_q, tick_count_d;
   logic        tick_pulse_q, tick_pulse_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         period_q     <= 32'h0;
         rd_phase_q   <= 1'b0;
         snap_lo_q    <= 16'h0;
         snap_q       <= 32'h0;
         tick_count_q <= 32'h0;
         tick_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         rd_phase_q   <= rd_phase_d;
         snap_lo_q    <= snap_lo_d;
         snap_q       <= snap_d;
         tick_count_q <= tick_count_d;
         tick_pulse_q <= tick_pulse_d;
      end
   end

   // Bus outputs decode from state_q alone, so an asynchronous reset drops them immediately.
   always_comb begin
      state_d          = state_q;
      period_d         = period_q;
      rd_phase_d       = 1'b0;
      snap_lo_d        = snap_lo_q;
      snap_d           = snap_q;
      tick_count_d     = tick_count_q;
      tick_pulse_d     = 1'b0;
      av.av_chipselect = 1'b0;
      av.av_write_n    = 1'b1;
      av.av_address    = 3'd0;
      av.av_writedata  = 16'h0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               period_d = (period == 32'h0) ? DEFAULT_PERIOD : period;
               state_d  = WR_PERL;
            end
         end
         WR_PERL: begin
            av.av_chipselect = 1'b1;
            av.av_write_n    = 1'b0;
            av.av_address    = 3'd2;
            av.av_writedata  = period_q[15:0];
            state_d          = WR_PERH;
         end
         WR_PERH: begin
            av.av_chipselect = 1'b1;
            av.av_write_n    = 1'b0;
            av.av_address    = 3'd3;
            av.av_writedata  = period_q[31:16];
            state_d          = WR_CTRL;
         end
         WR_CTRL: begin
            av.av_chipselect = 1'b1;
            av.av_write_n    = 1'b0;
            av.av_address    = 3'd1;
            av.av_writedata  = {12'h000, 1'b0, 1'b1, CONTINUOUS, 1'b1};
            state_d          = WAIT_IRQ;
         end
         WAIT_IRQ: begin
            // A pending interrupt is always serviced before a stop request.
            if (timer_irq) begin
               state_d = CLR;
            end else if (!enable) begin
               state_d = STOP;
            end
         end
         CLR: begin
            av.av_chipselect = 1'b1;
            av.av_write_n    = 1'b0;
            av.av_address    = 3'd0;
            state_d          = SNAP;
         end
         SNAP: begin
            av.av_chipselect = 1'b1;
            av.av_write_n    = 1'b0;
            av.av_address    = 3'd4;
            state_d          = RD_L;
         end
         RD_L: begin
            av.av_chipselect = 1'b1;
            av.av_address    = 3'd4;
            if (!rd_phase_q) begin
               rd_phase_d = 1'b1;
            end else begin
               snap_lo_d = av.av_readdata;
               state_d   = RD_H;
            end
         end
         RD_H: begin
            av.av_chipselect = 1'b1;
            av.av_address    = 3'd5;
            if (!rd_phase_q) begin
               rd_phase_d = 1'b1;
            end else begin
               snap_d       = {av.av_readdata, snap_lo_q};
               tick_count_d = tick_count_q + 32'd1;
               tick_pulse_d = 1'b1;
               state_d      = WAIT_IRQ;
            end
         end
         STOP: begin
            av.av_chipselect = 1'b1;
            av.av_write_n    = 1'b0;
            av.av_address    = 3'd1;
            av.av_writedata  = 16'h0008;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign tick_count = tick_count_q;
   assign tick_pulse = tick_pulse_q;
   assign snap_value = snap_q;
   assign busy       = (state_q != IDLE) && (state_q != WAIT_IRQ);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_nios2_freertos_tick_master.sv
// Bench for nios2_freertos_tick_master: timer slave model, bus scoreboard and
// a transaction-level reference model of programming, servicing and stopping.
module tb_nios2_freertos_tick_master;
   localparam logic [31:0] DEF_PERIOD = 32'd49999;
   localparam bit          CONT       = 1'b1;
   localparam int          W          = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] period = 32'h0;
   logic        timer_irq = 1'b0;
   logic [31:0] tick_count;
   logic        tick_pulse;
   logic [31:0] snap_value;
   logic        busy;
   logic [3:0]  state_dbg;

   nios2_freertos_tick_master_if av ();

   nios2_freertos_tick_master #(
      .DEFAULT_PERIOD(DEF_PERIOD),
      .CONTINUOUS    (CONT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .period    (period),
      .timer_irq (timer_irq),
      .av        (av),
      .tick_count(tick_count),
      .tick_pulse(tick_pulse),
      .snap_value(snap_value),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // timer slave: registered read data, one-cycle latency
   logic [15:0] rd_mem [8];
   always @(posedge clk) begin
      if (reset) av.av_readdata <= 16'h0;
      else if (av.av_chipselect && av.av_write_n) av.av_readdata <= rd_mem[av.av_address];
   end

   // scoreboard: every selected bus cycle is {is_write, address, write data or 0}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_got, mon_exp;
   int n_checks = 0;
   int n_pass = 0;
   int idle_err = 0;
   logic [31:0] model_ticks;
   logic [31:0] model_snap;

   always @(negedge clk) begin
      if (!reset) begin
         if (av.av_chipselect) begin
            mon_got = {!av.av_write_n, av.av_address, av.av_write_n ? 16'h0 : av.av_writedata};
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL bus_unexpected got=%h expected=none t=%0t", mon_got, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_got !== mon_exp) $display("FAIL bus_txn got=%h expected=%h t=%0t", mon_got, mon_exp, $time);
               else n_pass++;
            end
         end else if (av.av_write_n !== 1'b1 || av.av_address !== 3'd0 || av.av_writedata !== 16'h0) begin
            idle_err++;
         end
      end
   end

   function automatic logic [W-1:0] tr_wr(input logic [2:0] a, input logic [15:0] d);
      return {1'b1, a, d};
   endfunction

   function automatic logic [W-1:0] tr_rd(input logic [2:0] a);
      return {1'b0, a, 16'h0};
   endfunction

   // reference model
   function automatic logic [31:0] eff_period(input logic [31:0] p);
      return (p == 32'h0) ? DEF_PERIOD : p;
   endfunction

   task automatic push_program(input logic [31:0] p);
      logic [31:0] e;
      logic [15:0] ctrl;
      e = eff_period(p);
      ctrl = 16'h0004 | (CONT ? 16'h0002 : 16'h0000) | 16'h0001;
      exp_q.push_back(tr_wr(3'd2, e[15:0]));
      exp_q.push_back(tr_wr(3'd3, e[31:16]));
      exp_q.push_back(tr_wr(3'd1, ctrl));
   endtask

   task automatic model_service(input logic [15:0] lo, input logic [15:0] hi);
      exp_q.push_back(tr_wr(3'd0, 16'h0));
      exp_q.push_back(tr_wr(3'd4, 16'h0));
      exp_q.push_back(tr_rd(3'd4));
      exp_q.push_back(tr_rd(3'd4));
      exp_q.push_back(tr_rd(3'd5));
      exp_q.push_back(tr_rd(3'd5));
      model_snap  = {hi, lo};
      model_ticks = model_ticks + 32'd1;
   endtask

   // driver tasks (called at a falling edge, return at a falling edge)
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_irq(input int hold, input int total, input int drop_at, output int pulses, output int first);
      pulses = 0;
      first = -1;
      timer_irq = 1'b1;
      for (int i = 1; i <= total; i++) begin
         @(negedge clk);
         if (i == hold) timer_irq = 1'b0;
         if (i == drop_at) enable = 1'b0;
         if (tick_pulse === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      n_checks++; if (tick_count !== 32'h0) $display("FAIL rst_tick got=%h exp=0", tick_count); else n_pass++;
      n_checks++; if (snap_value !== 32'h0) $display("FAIL rst_snap got=%h exp=0", snap_value); else n_pass++;
      n_checks++; if (tick_pulse !== 1'b0) $display("FAIL rst_pulse got=%b exp=0", tick_pulse); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
      n_checks++;
      if (av.av_chipselect !== 1'b0 || av.av_write_n !== 1'b1 || av.av_address !== 3'd0 || av.av_writedata !== 16'h0)
         $display("FAIL rst_bus got cs=%b wn=%b a=%0d d=%h exp cs=0 wn=1 a=0 d=0",
                  av.av_chipselect, av.av_write_n, av.av_address, av.av_writedata);
      else n_pass++;
   endtask

   task automatic test_program(input logic [31:0] p, input bit glitch);
      enable = 1'b1;
      period = p;
      push_program(p);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL prog_busy got=%b exp=1", busy); else n_pass++;
      if (glitch) timer_irq = 1'b1;
      @(negedge clk);
      timer_irq = 1'b0;
      cycles(2);
      n_checks++; if (busy !== 1'b0) $display("FAIL prog_done_busy got=%b exp=0", busy); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL prog_pending got=%0d exp=0", exp_q.size()); else n_pass++;
      if (glitch) begin
         cycles(8);
         n_checks++; if (tick_count !== model_ticks) $display("FAIL irq_ignored_tick got=%h exp=%h", tick_count, model_ticks); else n_pass++;
      end
   endtask

   task automatic test_service(input logic [15:0] lo, input logic [15:0] hi);
      int pulses, first;
      rd_mem[4] = lo;
      rd_mem[5] = hi;
      model_service(lo, hi);
      run_irq(1, 8, 0, pulses, first);
      n_checks++; if (pulses != 1 || first != 7) $display("FAIL svc_pulse got n=%0d at=%0d exp n=1 at=7", pulses, first); else n_pass++;
      n_checks++; if (tick_count !== model_ticks) $display("FAIL svc_tick got=%h exp=%h", tick_count, model_ticks); else n_pass++;
      n_checks++; if (snap_value !== model_snap) $display("FAIL svc_snap got=%h exp=%h", snap_value, model_snap); else n_pass++;
      n_checks++; if (busy !== 1'b0 || exp_q.size() != 0) $display("FAIL svc_done got busy=%b pend=%0d exp 0/0", busy, exp_q.size()); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int pulses, first;
      logic [15:0] lo, hi;
      lo = 16'($urandom);
      hi = 16'($urandom);
      rd_mem[4] = lo;
      rd_mem[5] = hi;
      model_service(lo, hi);
      model_service(lo, hi);
      run_irq(8, 16, 0, pulses, first);
      n_checks++; if (pulses != 2 || first != 7) $display("FAIL b2b_pulse got n=%0d at=%0d exp n=2 at=7", pulses, first); else n_pass++;
      n_checks++; if (tick_count !== model_ticks) $display("FAIL b2b_tick got=%h exp=%h", tick_count, model_ticks); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_pending got=%0d exp=0", exp_q.size()); else n_pass++;
   endtask

   // drop_at=0 means enable falls together with the interrupt
   task automatic test_service_then_stop(input int drop_at, input string tag);
      int pulses, first;
      logic [15:0] lo, hi;
      lo = 16'($urandom);
      hi = 16'($urandom);
      rd_mem[4] = lo;
      rd_mem[5] = hi;
      model_service(lo, hi);
      exp_q.push_back(tr_wr(3'd1, 16'h0008));
      if (drop_at == 0) enable = 1'b0;
      run_irq(1, 9, drop_at, pulses, first);
      n_checks++; if (pulses != 1 || first != 7) $display("FAIL %s_pulse got n=%0d at=%0d exp n=1 at=7", tag, pulses, first); else n_pass++;
      n_checks++; if (snap_value !== model_snap) $display("FAIL %s_snap got=%h exp=%h", tag, snap_value, model_snap); else n_pass++;
      n_checks++; if (busy !== 1'b0 || exp_q.size() != 0) $display("FAIL %s_stop got busy=%b pend=%0d exp 0/0", tag, busy, exp_q.size()); else n_pass++;
      cycles(4);
      n_checks++; if (tick_count !== model_ticks) $display("FAIL %s_hold_tick got=%h exp=%h", tag, tick_count, model_ticks); else n_pass++;
   endtask

   task automatic test_wrap;
      force dut.tick_count_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.tick_count_q;
      model_ticks = 32'hFFFF_FFFF;
      @(negedge clk);
      n_checks++; if (tick_count !== model_ticks) $display("FAIL wrap_preset got=%h exp=%h", tick_count, model_ticks); else n_pass++;
      test_service(16'($urandom), 16'($urandom));
   endtask

   task automatic test_reset_mid;
      logic [31:0] p;
      p = $urandom;
      enable = 1'b1;
      period = p;
      push_program(p);
      cycles(2);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (av.av_chipselect !== 1'b0 || av.av_write_n !== 1'b1 || av.av_address !== 3'd0 || av.av_writedata !== 16'h0)
         $display("FAIL rstmid_bus got cs=%b wn=%b a=%0d d=%h exp cs=0 wn=1 a=0 d=0",
                  av.av_chipselect, av.av_write_n, av.av_address, av.av_writedata);
      else n_pass++;
      n_checks++;
      if (tick_count !== 32'h0 || snap_value !== 32'h0 || busy !== 1'b0 || tick_pulse !== 1'b0)
         $display("FAIL rstmid_out got tick=%h snap=%h busy=%b pulse=%b exp all 0", tick_count, snap_value, busy, tick_pulse);
      else n_pass++;
      exp_q.delete();
      model_ticks = 32'h0;
      model_snap = 32'h0;
      @(negedge clk);
      push_program(p);
      reset = 1'b0;
      cycles(4);
      n_checks++; if (busy !== 1'b0 || exp_q.size() != 0) $display("FAIL rstmid_reprog got busy=%b pend=%0d exp 0/0", busy, exp_q.size()); else n_pass++;
   endtask

   initial begin
      model_ticks = 32'h0;
      model_snap = 32'h0;
      for (int i = 0; i < 8; i++) rd_mem[i] = 16'h0;
      test_reset;
      reset = 1'b0;
      cycles(2);
      test_program(32'h0, 1'b1);
      test_service(16'h1234, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         cycles($urandom_range(0, 4));
         test_service(16'($urandom), 16'($urandom));
      end
      test_back_to_back;
      test_service_then_stop(3, "drop_rdl");
      test_program($urandom, 1'b0);
      test_service(16'($urandom), 16'($urandom));
      test_service_then_stop(0, "irq_and_off");
      test_program(($urandom_range(0, 1) == 0) ? 32'h0 : $urandom, 1'b0);
      test_wrap;
      test_reset_mid;
      test_service(16'($urandom), 16'($urandom));
      cycles(2);
      n_checks++; if (idle_err != 0) $display("FAIL idle_bus got=%0d exp=0", idle_err); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL final_pending got=%0d exp=0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
